// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the direct-mapped data cache
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  localparam int LINE_W = 256;
  localparam int OFF_W = 5;
  localparam int WSEL_W = 3;
  function automatic int tag_w(input int lines);
    return 32 - OFF_W - $clog2(lines);
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data arrays with sync write and comb read
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int IDX = $clog2(LINES),
  parameter int TAG_W = tag_w(LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX-1:0]    idx,
  input  logic              fill_we,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] data [LINES];
  // Line status: reset invalidates everything, a fill makes the line clean, a word write dirties it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) begin
      dirty[idx] <= 1'b1;
    end
  end
  // Tag and data storage, never cleared; whole-line fill or single-word merge
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_line;
    end else if (word_we) begin
      data[idx][{word_sel, 5'd0} +: 32] <= word_data;
    end
  end
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache with miss FSM
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);
  localparam int IDX = $clog2(LINES);
  localparam int TAG_W = tag_w(LINES);
  state_t state, next_state;
  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              rd_valid, rd_dirty, hit, fill_we, word_we;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              unused_addr;
  assign word_sel    = cpu_addr_i[4:2];
  assign idx         = cpu_addr_i[OFF_W +: IDX];
  assign req_tag     = cpu_addr_i[31:OFF_W+IDX];
  assign unused_addr = ^cpu_addr_i[1:0];
  assign hit         = rd_valid & (rd_tag == req_tag);
  dcache_sram #(.LINES(LINES)) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (idx),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_line (mem_rdata_i),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (cpu_wdata_i),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line)
  );
  // State register; reset abandons any in-flight miss
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= next_state;
  end
  // Miss handling: evict a dirty victim first, then fill, then retry the lookup in IDLE
  always_comb begin
    next_state = state == IDLE      ? ((cpu_req_i & ~hit) ? (rd_valid & rd_dirty ? WRITEBACK : ALLOCATE) : IDLE) :
                 state == WRITEBACK ? (mem_ack_i ? ALLOCATE : WRITEBACK) :
                                      (mem_ack_i ? IDLE : ALLOCATE);
  end
  // Outputs: stall, memory port muxing, load word select and array write strobes
  always_comb begin
    cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit);
    mem_req_o   = state != IDLE;
    mem_we_o    = state == WRITEBACK;
    mem_addr_o  = state == WRITEBACK ? {rd_tag, idx, {OFF_W{1'b0}}} :
                  state == ALLOCATE  ? {req_tag, idx, {OFF_W{1'b0}}} : '0;
    mem_wdata_o = state == WRITEBACK ? rd_line : '0;
    cpu_rdata_o = (state == IDLE && cpu_req_i && !cpu_we_i && hit) ? rd_line[{word_sel, 5'd0} +: 32] : '0;
    word_we     = (state == IDLE) & cpu_req_i & cpu_we_i & hit & ~rst_i;
    fill_we     = (state == ALLOCATE) & mem_ack_i & ~rst_i;
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized self-checking bench with an architectural memory model
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst, cpu_req, cpu_we, cpu_stall, mem_req, mem_we, mem_ack;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  int vectors = 0, miscompares = 0;
  int lat = 1, inject_reqs = 0, inject_done = 0, fill_cnt = 0, wb_cnt = 0;
  bit resp_en = 1'b1;
  logic [31:0]  last_fill_addr = '0, last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;
  logic [255:0] mem_model [logic [26:0]];
  logic [255:0] arch [logic [26:0]];
  logic [21:0]  ctag [32];
  bit           cval [32];
  bit           cdirty [32];

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .cpu_stall_o(cpu_stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic void touch(input logic [26:0] la);
    if (!mem_model.exists(la)) begin
      mem_model[la] = rand_line();
      arch[la] = mem_model[la];
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      cval[i] = 1'b0;
      cdirty[i] = 1'b0;
    end
    arch = mem_model;
  endfunction

  // Slow memory: acks in the lat-th cycle of each request state
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (inject_done < inject_reqs) begin
        inject_done++;
        mem_ack = 1'b1;
        mem_rdata = rand_line();
      end else if (mem_req === 1'b1 && resp_en) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            wb_cnt++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
            mem_model[mem_addr[31:5]] = mem_wdata;
          end else begin
            fill_cnt++;
            last_fill_addr = mem_addr;
            touch(mem_addr[31:5]);
            mem_rdata = mem_model[mem_addr[31:5]];
          end
        end
      end else cnt = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata, output int stalls);
    logic [26:0]  la, vla;
    logic [21:0]  tag;
    logic [255:0] l;
    int idx, w, exp_stall, f0, w0;
    bit hit, dev;
    la = addr[31:5];
    idx = int'(addr[9:5]);
    tag = addr[31:10];
    w = int'(addr[4:2]);
    hit = cval[idx] && ctag[idx] == tag;
    dev = !hit && cval[idx] && cdirty[idx];
    vla = {ctag[idx], addr[9:5]};
    exp_stall = hit ? 0 : (dev ? 1 + 2 * lat : 1 + lat);
    f0 = fill_cnt;
    w0 = wb_cnt;
    stalls = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    while (cpu_stall && stalls < 300) begin
      stalls++;
      @(negedge clk); #1;
    end
    vectors++;
    if (stalls != exp_stall) begin
      miscompares++;
      $display("FAIL stall_cycles addr=%h: got %0d expected %0d", addr, stalls, exp_stall);
    end
    vectors++;
    if (fill_cnt - f0 != (hit ? 0 : 1) || wb_cnt - w0 != (dev ? 1 : 0)) begin
      miscompares++;
      $display("FAIL mem_traffic addr=%h: got fills=%0d wbs=%0d expected fills=%0d wbs=%0d",
               addr, fill_cnt - f0, wb_cnt - w0, hit ? 0 : 1, dev ? 1 : 0);
    end
    if (!hit) begin
      vectors++;
      if (last_fill_addr !== {la, 5'b0}) begin
        miscompares++;
        $display("FAIL fill_addr: got %h expected %h", last_fill_addr, {la, 5'b0});
      end
    end
    if (dev) begin
      vectors++;
      if (last_wb_addr !== {vla, 5'b0} || last_wb_data !== arch[vla]) begin
        miscompares++;
        $display("FAIL wb_line: got addr %h data %h expected addr %h data %h",
                 last_wb_addr, last_wb_data, {vla, 5'b0}, arch[vla]);
      end
    end
    if (!we) begin
      vectors++;
      l = arch[la];
      if (cpu_rdata !== l[w*32 +: 32]) begin
        miscompares++;
        $display("FAIL load_data addr=%h: got %h expected %h", addr, cpu_rdata, l[w*32 +: 32]);
      end
    end else begin
      l = arch[la];
      l[w*32 +: 32] = wdata;
      arch[la] = l;
    end
    cdirty[idx] = (hit && cdirty[idx]) || we;
    cval[idx] = 1'b1;
    ctag[idx] = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || cpu_rdata !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b req=%b we=%b rdata=%h addr=%h expected all zero",
               cpu_stall, mem_req, mem_we, cpu_rdata, mem_addr);
    end
  endtask

  task automatic test_cold_load();
    logic [255:0] l;
    int s;
    l = rand_line();
    l[31:0] = 32'hDEAD_BEEF;
    mem_model[27'h2] = l;
    arch[27'h2] = l;
    lat = 10;
    access(1'b0, 32'h0000_0040, '0, s);
    vectors++;
    if (s != 11 || cpu_rdata !== 32'hDEAD_BEEF || last_fill_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL cold_load: got stall=%0d rdata=%h fill=%h expected 11 deadbeef 40", s, cpu_rdata, last_fill_addr);
    end
  endtask

  task automatic test_store_hit();
    int s, t, n;
    n = fill_cnt + wb_cnt;
    access(1'b1, 32'h44, 32'h1234_5678, s);
    access(1'b0, 32'h44, '0, t);
    vectors++;
    if (s != 0 || t != 0 || cpu_rdata !== 32'h1234_5678 || fill_cnt + wb_cnt != n) begin
      miscompares++;
      $display("FAIL store_hit: got stalls=%0d/%0d rdata=%h reqs=%0d expected 0/0 12345678 0",
               s, t, cpu_rdata, fill_cnt + wb_cnt - n);
    end
  endtask

  task automatic test_dirty_evict();
    int s;
    access(1'b0, 32'h440, '0, s);
    vectors++;
    if (s != 21 || last_wb_addr !== 32'h40 || last_wb_data[63:32] !== 32'h1234_5678 || last_fill_addr !== 32'h440) begin
      miscompares++;
      $display("FAIL dirty_evict: got stall=%0d wb=%h w1=%h fill=%h expected 21 40 12345678 440",
               s, last_wb_addr, last_wb_data[63:32], last_fill_addr);
    end
  endtask

  task automatic test_store_miss();
    int s, t;
    lat = 3;
    access(1'b1, 32'h80, 32'hA5A5_A5A5, s);
    access(1'b0, 32'h880, '0, t);
    vectors++;
    if (s != 4 || t != 7 || last_wb_addr !== 32'h80 || last_wb_data[31:0] !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL store_miss: got stalls=%0d/%0d wb=%h w0=%h expected 4/7 80 a5a5a5a5",
               s, t, last_wb_addr, last_wb_data[31:0]);
    end
  endtask

  task automatic test_idle_ack();
    int s;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inject_reqs++;
      repeat (3) @(negedge clk);
      vectors++;
      if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ack: got stall=%b req=%b expected 0 0", cpu_stall, mem_req);
      end
    end
    access(1'b0, 32'h444, '0, s);
  endtask

  task automatic test_reset_mid_miss();
    int s;
    lat = 10;
    resp_en = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC0;
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'hC0 || cpu_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL alloc_req: got req=%b we=%b addr=%h stall=%b expected 1 0 c0 1", mem_req, mem_we, mem_addr, cpu_stall);
    end
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_miss: got req=%b stall=%b expected 0 0", mem_req, cpu_stall);
    end
    inject_reqs++;
    repeat (3) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack: got req=%b stall=%b expected 0 0", mem_req, cpu_stall);
    end
    resp_en = 1'b1;
    access(1'b0, 32'hC0, '0, s);
    vectors++;
    if (s != 11) begin
      miscompares++;
      $display("FAIL remiss_after_reset: got stall=%0d expected 11", s);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      lat = int'($urandom_range(1, 4));
      a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b0};
      access(1'($urandom_range(0, 1)), a, $urandom, s);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_store_miss();
    test_idle_ack();
    test_reset_mid_miss();
    test_back_to_back();
    @(negedge clk);
    cpu_req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
